// File: rtl/barrel_shift_pipe_pkg.sv
// barrel_pkg: shared op encodings and bit-reversal helper for barrel_shift_pipe
//   op_t     2-bit operation code (ROR/ROL/SRL/SRA)
//   bit_rev  reverses the low w bits of a MAX_W-wide vector
package barrel_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_ROR = 2'b00;
    localparam op_t OP_ROL = 2'b01;
    localparam op_t OP_SRL = 2'b10;
    localparam op_t OP_SRA = 2'b11;
    localparam int MAX_W = 1024;
    // Reverse the whole MAX_W vector, then shift the w interesting bits back down to the LSBs.
    function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] d, input int unsigned w);
        logic [MAX_W-1:0] r;
        r = {<<{d}};
        return r >> (MAX_W - w);
    endfunction
endpackage

// File: rtl/barrel_shift_pipe_if.sv
// barrel_shift_pipe_if: valid/ready bus of the shift unit
//   in_*   op channel into the shifter (in_ready driven by the shifter)
//   out_*  result channel out of the shifter (out_ready driven by the consumer)
//   master: producer/consumer side, slave: shifter side
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    import barrel_pkg::*;
    localparam int SAMT_W = $clog2(WIDTH);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [SAMT_W-1:0] in_samt;
    op_t               in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    modport master (
        output in_valid, in_data, in_samt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
    modport slave (
        input  in_valid, in_data, in_samt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/barrel_shift_pipe_stage.sv
// barrel_stage: one pipeline stage, conditional right shift by SHIFT with fill select
//   clk, rst          clock, synchronous active-high reset
//   *_i               upstream stage contents (valid, data, samt, op, sign, tag)
//   nxt_load_i        downstream stage loads (or output accepted)
//   load_o            this stage captures upstream this cycle
//   *_o               registered stage contents
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    parameter int SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     v_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] samt_i,
    input  op_t                      op_i,
    input  logic                     sign_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic                     nxt_load_i,
    output logic                     load_o,
    output logic                     v_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(WIDTH)-1:0] samt_o,
    output op_t                      op_o,
    output logic                     sign_o,
    output logic [TAG_W-1:0]         tag_o
);
    localparam int BIT = $clog2(SHIFT);
    logic                     v_q, sign_q;
    logic [WIDTH-1:0]         data_d, data_q;
    logic [$clog2(WIDTH)-1:0] samt_q;
    op_t                      op_q;
    logic [TAG_W-1:0]         tag_q;
    logic [SHIFT-1:0]         fill;
    // Rotates (left ops arrive pre-reversed) refill with the bits shifted out.
    always_comb begin
        fill = op_i == OP_SRL ? '0 : op_i == OP_SRA ? {SHIFT{sign_i}} : data_i[SHIFT-1:0];
        data_d = samt_i[BIT] ? {fill, data_i[WIDTH-1:SHIFT]} : data_i;
    end
    assign load_o = !v_q || nxt_load_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
            samt_q <= '0;
            op_q   <= OP_ROR;
            sign_q <= 1'b0;
            tag_q  <= '0;
        end else if (load_o) begin
            v_q    <= v_i;
            data_q <= data_d;
            samt_q <= samt_i;
            op_q   <= op_i;
            sign_q <= sign_i;
            tag_q  <= tag_i;
        end
    end
    assign v_o    = v_q;
    assign data_o = data_q;
    assign samt_o = samt_q;
    assign op_o   = op_q;
    assign sign_o = sign_q;
    assign tag_o  = tag_q;
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter/rotator, one stage per shift-amount bit
//   clk, rst  clock, synchronous active-high reset
//   bus       barrel_shift_pipe_if.slave: in_* op channel, out_* result channel
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input logic               clk,
    input logic               rst,
    barrel_shift_pipe_if.slave bus
);
    localparam int NSTG = $clog2(WIDTH);
    // Index 0 is the entry point; index k+1 is the output of stage k.
    logic [NSTG:0]             v, ld, sgn;
    logic [NSTG:0][WIDTH-1:0]  d;
    logic [NSTG:0][NSTG-1:0]   samt;
    op_t  [NSTG:0]             op;
    logic [NSTG:0][TAG_W-1:0]  tag;
    logic                      unused_tail;
    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        return WIDTH'(bit_rev(MAX_W'(x), WIDTH));
    endfunction
    // Left rotates run through the right-only core on a reversed operand.
    assign v[0]    = bus.in_valid;
    assign d[0]    = bus.in_op == OP_ROL ? rev(bus.in_data) : bus.in_data;
    assign samt[0] = bus.in_samt;
    assign op[0]   = bus.in_op;
    assign sgn[0]  = bus.in_data[WIDTH-1];
    assign tag[0]  = bus.in_tag;
    assign ld[NSTG] = bus.out_ready;
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        barrel_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SHIFT(1 << k)) u_stg (
            .clk        (clk),
            .rst        (rst),
            .v_i        (v[k]),
            .data_i     (d[k]),
            .samt_i     (samt[k]),
            .op_i       (op[k]),
            .sign_i     (sgn[k]),
            .tag_i      (tag[k]),
            .nxt_load_i (ld[k+1]),
            .load_o     (ld[k]),
            .v_o        (v[k+1]),
            .data_o     (d[k+1]),
            .samt_o     (samt[k+1]),
            .op_o       (op[k+1]),
            .sign_o     (sgn[k+1]),
            .tag_o      (tag[k+1])
        );
    end
    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v[NSTG];
    assign bus.out_data  = op[NSTG] == OP_ROL ? rev(d[NSTG]) : d[NSTG];
    assign bus.out_tag   = tag[NSTG];
    assign unused_tail   = ^{samt[NSTG], sgn[NSTG]};
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed and streaming checks of barrel_shift_pipe at WIDTH=64, TAG_W=4
module tb_barrel_shift_pipe;
    import barrel_pkg::*;
    typedef struct {
        logic [63:0] d;
        logic [5:0]  s;
        op_t         o;
        logic [3:0]  t;
        logic [63:0] e;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    barrel_shift_pipe_if #(.WIDTH(64), .TAG_W(4)) bus();
    barrel_shift_pipe #(.WIDTH(64), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [63:0] model(input logic [63:0] d, input logic [5:0] s, input op_t o);
        case (o)
            OP_ROR:  return (d >> s) | (d << (7'd64 - s));
            OP_ROL:  return (d << s) | (d >> (7'd64 - s));
            OP_SRL:  return d >> s;
            default: return $signed(d) >>> s;
        endcase
    endfunction
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask
    task automatic test_reset;
        int seen = 0;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_samt = 6'd0;
        bus.in_op = OP_ROR;
        bus.in_tag = 4'hF;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL reset_ignored_input: got %0d results expected 0", seen); end
    endtask
    task automatic test_directed;
        vec_t tv[6];
        tv = '{
            '{64'h0123456789ABCDEF, 6'd4,  OP_ROR, 4'd3, 64'hF0123456789ABCDE},
            '{64'h0123456789ABCDEF, 6'd8,  OP_ROL, 4'd4, 64'h23456789ABCDEF01},
            '{64'h8000000000000000, 6'd63, OP_SRL, 4'd5, 64'h0000000000000001},
            '{64'h8000000000000000, 6'd63, OP_SRA, 4'd6, 64'hFFFFFFFFFFFFFFFF},
            '{64'h7000000000000000, 6'd4,  OP_SRA, 4'd7, 64'h0700000000000000},
            '{64'h8000000000000001, 6'd63, OP_ROL, 4'd8, 64'hC000000000000000}
        };
        idle(2);
        foreach (tv[i]) begin
            int lat;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = tv[i].d;
            bus.in_samt = tv[i].s;
            bus.in_op = tv[i].o;
            bus.in_tag = tv[i].t;
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== 6) begin failures++; $display("FAIL directed%0d_latency: got %0d expected 6", i, lat); end
            checks++; if (bus.out_data !== tv[i].e) begin failures++; $display("FAIL directed%0d_data: got %h expected %h", i, bus.out_data, tv[i].e); end
            checks++; if (bus.out_tag !== tv[i].t) begin failures++; $display("FAIL directed%0d_tag: got %h expected %h", i, bus.out_tag, tv[i].t); end
        end
    endtask
    task automatic test_samt_zero;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            int lat;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = 64'hDEADBEEFCAFEF00D;
            bus.in_samt = 6'd0;
            bus.in_op = op_t'(i);
            bus.in_tag = 4'(i + 9);
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (bus.out_data !== 64'hDEADBEEFCAFEF00D) begin failures++; $display("FAIL samt0_op%0d_data: got %h expected deadbeefcafef00d", i, bus.out_data); end
            checks++; if (bus.out_tag !== 4'(i + 9)) begin failures++; $display("FAIL samt0_op%0d_tag: got %h expected %h", i, bus.out_tag, 4'(i + 9)); end
        end
    endtask
    task automatic test_back_to_back;
        logic [67:0] exp_q[$];
        logic [63:0] d;
        logic [5:0]  s;
        op_t         o;
        logic [3:0]  t;
        int sent = 0, got = 0, cyc = 0, stalls = 0;
        idle(2);
        while ((sent < 100 || got < 100) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra: got %h with nothing expected", bus.out_data);
                end else begin
                    if ({bus.out_tag, bus.out_data} !== exp_q[0]) begin failures++; $display("FAIL b2b_result%0d: got %h_%h expected %h", got, bus.out_tag, bus.out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (sent < 100) begin
                d = {$urandom, $urandom};
                s = 6'($urandom_range(0, 63));
                o = op_t'($urandom_range(0, 3));
                t = 4'($urandom_range(0, 15));
                bus.in_valid = 1'b1;
                bus.in_data = d;
                bus.in_samt = s;
                bus.in_op = o;
                bus.in_tag = t;
                #1;
                if (bus.in_ready === 1'b1) begin
                    exp_q.push_back({t, model(d, s, o)});
                    sent++;
                end else stalls++;
            end else bus.in_valid = 1'b0;
        end
        checks++; if (got !== 100) begin failures++; $display("FAIL b2b_count: got %0d expected 100", got); end
        checks++; if (stalls !== 0) begin failures++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
        checks++; if (cyc !== 106) begin failures++; $display("FAIL b2b_cycles: got %0d expected 106", cyc); end
    endtask
    task automatic test_backpressure;
        logic [67:0] exp_q[$];
        logic [67:0] held = '0;
        logic [63:0] d[8];
        logic [5:0]  s[8];
        op_t         o[8];
        int idx = 0, got = 0, cyc = 0, have = 0, unstable = 0, extra = 0;
        for (int i = 0; i < 8; i++) begin
            d[i] = 64'h1111_2222_3333_4445 * 64'(i + 1);
            s[i] = 6'(i * 7 + 1);
            o[i] = op_t'(i % 4);
        end
        idle(2);
        bus.out_ready = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (have != 0 && {bus.out_tag, bus.out_data} !== held) unstable++;
                held = {bus.out_tag, bus.out_data};
                have = 1;
            end
            if (idx < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data = d[idx];
                bus.in_samt = s[idx];
                bus.in_op = o[idx];
                bus.in_tag = 4'(idx);
                #1;
                if (bus.in_ready === 1'b1) begin
                    exp_q.push_back({4'(idx), model(d[idx], s[idx], o[idx])});
                    idx++;
                end
            end
        end
        checks++; if (idx !== 6) begin failures++; $display("FAIL bp_accepted: got %0d expected 6", idx); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (unstable !== 0 || have == 0) begin failures++; $display("FAIL bp_hold: got %0d changes (seen %0d) expected 0 changes", unstable, have); end
        checks++; if ({bus.out_tag, bus.out_data} !== {4'd0, model(d[0], s[0], o[0])}) begin failures++; $display("FAIL bp_head: got %h_%h expected %h", bus.out_tag, bus.out_data, model(d[0], s[0], o[0])); end
        bus.out_ready = 1'b1;
        while (got < 8 && cyc < 40) begin
            if (bus.out_valid === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra: got %h with nothing expected", bus.out_data);
                end else begin
                    if ({bus.out_tag, bus.out_data} !== exp_q[0]) begin failures++; $display("FAIL bp_result%0d: got %h_%h expected %h", got, bus.out_tag, bus.out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (idx < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data = d[idx];
                bus.in_samt = s[idx];
                bus.in_op = o[idx];
                bus.in_tag = 4'(idx);
                #1;
                if (bus.in_ready === 1'b1) begin
                    exp_q.push_back({4'(idx), model(d[idx], s[idx], o[idx])});
                    idx++;
                end
            end else bus.in_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (got !== 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", got); end
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL bp_duplicate: got %0d extra results expected 0", extra); end
    endtask
    task automatic test_reset_mid_flight;
        int seen = 0, lat;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = 64'hA5A5_0000_0000_0001 + 64'(i);
            bus.in_samt = 6'(i + 1);
            bus.in_op = OP_ROL;
            bus.in_tag = 4'(4'hA + i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'h0) begin failures++; $display("FAIL rstmid_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_tag !== 4'h0) begin failures++; $display("FAIL rstmid_out_tag: got %h expected 0", bus.out_tag); end
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_ghosts: got %0d results expected 0", seen); end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 64'h0000_0000_0000_0003;
        bus.in_samt = 6'd1;
        bus.in_op = OP_ROR;
        bus.in_tag = 4'h5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 6) begin failures++; $display("FAIL rstmid_latency: got %0d expected 6", lat); end
        checks++; if (bus.out_data !== 64'h8000_0000_0000_0001) begin failures++; $display("FAIL rstmid_data: got %h expected 8000000000000001", bus.out_data); end
        checks++; if (bus.out_tag !== 4'h5) begin failures++; $display("FAIL rstmid_tag: got %h expected 5", bus.out_tag); end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_samt = '0;
        bus.in_op = OP_ROR;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        test_reset;
        test_directed;
        test_samt_zero;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_flight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
